// File: rtl/cl_thread_state_ctrl_pkg.sv
// Shared definitions for the multi-thread run-state controller: thread state
// encoding, thread-id sizing helper and the WAIT instruction pattern.
package cl_thread_state_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_ERR   = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

    // Instruction word decode compares against to flag a WAIT.
    localparam logic [31:0] K_WAIT = 32'h1050_0073;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_NUM_THREADS = 4;
    localparam int unsigned DEF_TID_W       = clog2_min1(DEF_NUM_THREADS);

    typedef logic [DEF_TID_W-1:0] tid_t;

endpackage

// File: rtl/cl_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping mod N.
module cl_rr_arbiter
    import cl_thread_state_ctrl_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned TID_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [TID_W-1:0] ptr,
    input  logic             hold,
    output logic [N-1:0]     gnt_onehot_c,
    output logic [TID_W-1:0] gnt_tid_c,
    output logic             gnt_v_c
);

    logic [TID_W-1:0] idx;

    always_comb begin
        gnt_onehot_c = '0;
        gnt_tid_c    = '0;
        gnt_v_c      = 1'b0;
        idx          = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = TID_W'((32'(ptr) + i) % N);
            if (!hold && !gnt_v_c && req[idx]) begin
                gnt_v_c           = 1'b1;
                gnt_tid_c         = idx;
                gnt_onehot_c[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cl_thread_state_ctrl.sv
// Per-thread IDLE/RUN/ERR/DRAIN state, round-robin fetch grant and error counter.
// Optional per-thread RUN watchdog enabled by defining CL_THREAD_WATCHDOG_EN.
module cl_thread_state_ctrl
    import cl_thread_state_ctrl_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned TID_W       = clog2_min1(NUM_THREADS),
    parameter int unsigned ERR_CNT_W   = 8,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic [NUM_THREADS-1:0]   start_i,
    input  logic [NUM_THREADS-1:0]   clear_err_i,
    input  logic                     issue_v_i,
    input  logic [TID_W-1:0]         issue_tid_i,
    input  logic                     is_wait_i,
    input  logic                     exception_i,
    input  logic                     stall_i,
    input  logic [NUM_THREADS-1:0]   inflight_i,
    output logic [NUM_THREADS*2-1:0] state_o,
    output logic                     grant_v_o,
    output logic [TID_W-1:0]         grant_tid_o,
    output logic                     any_err_o,
    output logic [ERR_CNT_W-1:0]     err_cnt_o
);

    localparam int unsigned SUM_W = ERR_CNT_W + 5;

    state_e                 state_q [NUM_THREADS];
    state_e                 state_d [NUM_THREADS];
    logic [NUM_THREADS-1:0] retire_c;
    logic [NUM_THREADS-1:0] wdog_hit_c;
    logic [NUM_THREADS-1:0] run_next_c;
    logic [NUM_THREADS-1:0] err_now_c;
    logic [SUM_W-1:0]       err_sum_c;
    logic [ERR_CNT_W-1:0]   err_cnt_d;
    logic                   tid_ok_c;
    logic [TID_W-1:0]       ptr_q;
    logic                   grant_v_q;
    logic [TID_W-1:0]       grant_tid_q;
    logic                   any_err_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;
    logic [NUM_THREADS-1:0] unused_onehot_c;
    logic [TID_W-1:0]       arb_tid_c;
    logic                   arb_v_c;

    assign tid_ok_c = 32'(issue_tid_i) < 32'(NUM_THREADS);

    always_comb begin
        retire_c = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            retire_c[t] = issue_v_i && !stall_i && tid_ok_c && (issue_tid_i == TID_W'(t));
        end
    end

`ifdef CL_THREAD_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_q [NUM_THREADS];

    // Fires on the cycle whose edge would bring the idle count to WDOG_CYCLES.
    always_comb begin
        wdog_hit_c = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            wdog_hit_c[t] = (state_q[t] == ST_RUN) && !retire_c[t]
                            && (wdog_q[t] == WDOG_W'(WDOG_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int t = 0; t < NUM_THREADS; t++) wdog_q[t] <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                wdog_q[t] <= ((state_q[t] == ST_RUN) && !retire_c[t])
                             ? wdog_q[t] + WDOG_W'(1) : '0;
            end
        end
    end
`else
    logic unused_wdog_c;

    assign wdog_hit_c    = '0;
    assign unused_wdog_c = |32'(WDOG_CYCLES);
`endif

    // Per-thread next state; exception/watchdog outranks every other event.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            state_d[t] = state_q[t];
            if (((retire_c[t] && exception_i) || wdog_hit_c[t])
                && ((state_q[t] == ST_RUN) || (state_q[t] == ST_DRAIN))) begin
                state_d[t] = ST_ERR;
            end else begin
                case (state_q[t])
                    ST_ERR:   if (clear_err_i[t]) state_d[t] = ST_IDLE;
                    ST_IDLE:  if (start_i[t]) state_d[t] = ST_RUN;
                    ST_RUN:   if (retire_c[t] && is_wait_i) state_d[t] = ST_DRAIN;
                    ST_DRAIN: if (!inflight_i[t]) state_d[t] = start_i[t] ? ST_RUN : ST_IDLE;
                    default:  state_d[t] = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        run_next_c = '0;
        err_now_c  = '0;
        err_sum_c  = SUM_W'(err_cnt_q);
        for (int t = 0; t < NUM_THREADS; t++) begin
            run_next_c[t] = (state_d[t] == ST_RUN);
            err_now_c[t]  = (state_q[t] == ST_ERR);
            if ((state_d[t] == ST_ERR) && (state_q[t] != ST_ERR)) begin
                err_sum_c = err_sum_c + SUM_W'(1);
            end
        end
        err_cnt_d = (err_sum_c > SUM_W'({ERR_CNT_W{1'b1}})) ? '1 : ERR_CNT_W'(err_sum_c);
    end

    cl_rr_arbiter #(
        .N     (NUM_THREADS),
        .TID_W (TID_W)
    ) u_arb (
        .req          (run_next_c),
        .ptr          (ptr_q),
        .hold         (stall_i),
        .gnt_onehot_c (unused_onehot_c),
        .gnt_tid_c    (arb_tid_c),
        .gnt_v_c      (arb_v_c)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int t = 0; t < NUM_THREADS; t++) state_q[t] <= ST_IDLE;
            grant_v_q   <= 1'b0;
            grant_tid_q <= '0;
            ptr_q       <= '0;
            any_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) state_q[t] <= state_d[t];
            any_err_q <= |err_now_c;
            err_cnt_q <= err_cnt_d;
            // Stall freezes both the grant and the round-robin pointer.
            if (!stall_i) begin
                grant_v_q <= arb_v_c;
                if (arb_v_c) begin
                    grant_tid_q <= arb_tid_c;
                    ptr_q       <= arb_tid_c;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_reset && issue_v_i && !stall_i) begin
            assert (tid_ok_c);
        end
    end

    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_state_out
        assign state_o[2*g +: 2] = state_q[g];
    end

    assign grant_v_o   = grant_v_q;
    assign grant_tid_o = grant_tid_q;
    assign any_err_o   = any_err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_cl_thread_state_ctrl.sv
// Directed bench for cl_thread_state_ctrl (default build, 4 threads, 8-bit error counter).
module tb_cl_thread_state_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned TW = 2;
    localparam int unsigned CW = 8;

    logic            clk = 1'b0;
    logic            n_reset;
    logic [N-1:0]    start_i, clear_err_i, inflight_i;
    logic            issue_v_i, is_wait_i, exception_i, stall_i;
    logic [TW-1:0]   issue_tid_i;
    logic [2*N-1:0]  state_o;
    logic            grant_v_o;
    logic [TW-1:0]   grant_tid_o;
    logic            any_err_o;
    logic [CW-1:0]   err_cnt_o;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    cl_thread_state_ctrl #(
        .NUM_THREADS (N),
        .TID_W       (TW),
        .ERR_CNT_W   (CW),
        .WDOG_CYCLES (16)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .start_i     (start_i),
        .clear_err_i (clear_err_i),
        .issue_v_i   (issue_v_i),
        .issue_tid_i (issue_tid_i),
        .is_wait_i   (is_wait_i),
        .exception_i (exception_i),
        .stall_i     (stall_i),
        .inflight_i  (inflight_i),
        .state_o     (state_o),
        .grant_v_o   (grant_v_o),
        .grant_tid_o (grant_tid_o),
        .any_err_o   (any_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0; start_i = '0; clear_err_i = '0; inflight_i = '0;
        issue_v_i = 1'b0; issue_tid_i = '0; is_wait_i = 1'b0; exception_i = 1'b0; stall_i = 1'b0;
        #12;
        checks++; if (state_o !== 8'h00) $display("FAIL reset_state got %h exp 00", state_o); else passed++;
        checks++; if (grant_v_o !== 1'b0 || grant_tid_o !== 2'd0)
            $display("FAIL reset_grant got v=%b tid=%0d exp v=0 tid=0", grant_v_o, grant_tid_o); else passed++;
        checks++; if (any_err_o !== 1'b0 || err_cnt_o !== 8'd0)
            $display("FAIL reset_err got any=%b cnt=%0d exp 0/0", any_err_o, err_cnt_o); else passed++;
        @(negedge clk) n_reset = 1'b1;
        step();
    endtask

    task automatic test_rr_stall();
        int exp_tid [3] = '{0, 2, 0};
        start_i = 4'b0101;
        step();
        start_i = '0;
        checks++; if (state_o !== 8'h11) $display("FAIL rr_start_state got %h exp 11", state_o); else passed++;
        checks++; if (grant_v_o !== 1'b1 || grant_tid_o !== 2'd2)
            $display("FAIL rr_first_grant got v=%b tid=%0d exp v=1 tid=2", grant_v_o, grant_tid_o); else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (grant_v_o !== 1'b1 || grant_tid_o !== TW'(exp_tid[i]))
                $display("FAIL rr_alternate[%0d] got tid=%0d exp %0d", i, grant_tid_o, exp_tid[i]); else passed++;
        end
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (grant_v_o !== 1'b1 || grant_tid_o !== 2'd0)
                $display("FAIL rr_stall_hold[%0d] got v=%b tid=%0d exp v=1 tid=0", i, grant_v_o, grant_tid_o); else passed++;
        end
        stall_i = 1'b0;
        step();
        checks++; if (grant_tid_o !== 2'd2) $display("FAIL rr_after_stall got tid=%0d exp 2", grant_tid_o); else passed++;
    endtask

    task automatic test_drain();
        issue_v_i = 1'b1; issue_tid_i = 2'd2; is_wait_i = 1'b1; inflight_i = 4'b0100;
        step();
        issue_v_i = 1'b0; is_wait_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            checks++; if (state_o !== 8'h31)
                $display("FAIL drain_state[%0d] got %h exp 31", i, state_o); else passed++;
            checks++; if (grant_v_o !== 1'b1 || grant_tid_o !== 2'd0)
                $display("FAIL drain_grant[%0d] got v=%b tid=%0d exp v=1 tid=0", i, grant_v_o, grant_tid_o); else passed++;
        end
        inflight_i = '0;
        step();
        checks++; if (state_o !== 8'h01) $display("FAIL drain_to_idle got %h exp 01", state_o); else passed++;
    endtask

    task automatic test_err();
        start_i = 4'b0010;
        step();
        start_i = '0;
        checks++; if (state_o !== 8'h05 || grant_tid_o !== 2'd1)
            $display("FAIL err_setup got state=%h tid=%0d exp 05/1", state_o, grant_tid_o); else passed++;
        stall_i = 1'b1; issue_v_i = 1'b1; issue_tid_i = 2'd1; exception_i = 1'b1; is_wait_i = 1'b1;
        step();
        checks++; if (state_o !== 8'h05 || err_cnt_o !== 8'd0 || grant_tid_o !== 2'd1)
            $display("FAIL err_stalled_exc got state=%h cnt=%0d tid=%0d exp 05/0/1", state_o, err_cnt_o, grant_tid_o); else passed++;
        stall_i = 1'b0;
        step();
        issue_v_i = 1'b0; exception_i = 1'b0; is_wait_i = 1'b0;
        checks++; if (state_o !== 8'h09 || err_cnt_o !== 8'd1 || any_err_o !== 1'b0)
            $display("FAIL err_entry got state=%h cnt=%0d any=%b exp 09/1/0", state_o, err_cnt_o, any_err_o); else passed++;
        step();
        checks++; if (any_err_o !== 1'b1) $display("FAIL err_any_delayed got %b exp 1", any_err_o); else passed++;
        start_i = 4'b0010;
        step();
        start_i = '0;
        checks++; if (state_o !== 8'h09) $display("FAIL err_start_ignored got %h exp 09", state_o); else passed++;
        start_i = 4'b0010; clear_err_i = 4'b0010;
        step();
        start_i = '0; clear_err_i = '0;
        checks++; if (state_o !== 8'h01) $display("FAIL err_clear_start got %h exp 01", state_o); else passed++;
        step();
        checks++; if (any_err_o !== 1'b0) $display("FAIL err_any_clear got %b exp 0", any_err_o); else passed++;
    endtask

    task automatic test_saturation();
        int exp_cnt = 1;
        for (int i = 0; i < 300; i++) begin
            start_i = 4'b0010;
            step();
            start_i = '0; issue_v_i = 1'b1; issue_tid_i = 2'd1; exception_i = 1'b1;
            step();
            issue_v_i = 1'b0; exception_i = 1'b0;
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            checks++; if (err_cnt_o !== CW'(exp_cnt))
                $display("FAIL sat_count[%0d] got %0d exp %0d", i, err_cnt_o, exp_cnt); else passed++;
            clear_err_i = 4'b0010;
            step();
            clear_err_i = '0;
        end
    endtask

    task automatic test_async_reset();
        start_i = 4'b0110;
        step();
        start_i = '0;
        checks++; if (state_o !== 8'h15) $display("FAIL areset_setup got %h exp 15", state_o); else passed++;
        #3;
        n_reset = 1'b0;
        #1;
        checks++; if (state_o !== 8'h00 || grant_v_o !== 1'b0 || grant_tid_o !== 2'd0)
            $display("FAIL areset_immediate got state=%h v=%b tid=%0d exp 00/0/0", state_o, grant_v_o, grant_tid_o); else passed++;
        checks++; if (err_cnt_o !== 8'd0 || any_err_o !== 1'b0)
            $display("FAIL areset_err got cnt=%0d any=%b exp 0/0", err_cnt_o, any_err_o); else passed++;
        @(negedge clk) n_reset = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        start_i = 4'b1000;
        step();
        start_i = '0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            checks++; if (grant_v_o !== 1'b1 || grant_tid_o !== 2'd3)
                $display("FAIL single_run[%0d] got v=%b tid=%0d exp v=1 tid=3", i, grant_v_o, grant_tid_o); else passed++;
        end
        issue_v_i = 1'b1; issue_tid_i = 2'd3; is_wait_i = 1'b1; inflight_i = 4'b1000;
        step();
        issue_v_i = 1'b0; is_wait_i = 1'b0;
        checks++; if (state_o !== 8'hC0 || grant_v_o !== 1'b0)
            $display("FAIL b2b_drain got state=%h v=%b exp C0/0", state_o, grant_v_o); else passed++;
        inflight_i = '0; start_i = 4'b1000;
        step();
        start_i = '0;
        checks++; if (state_o !== 8'h40 || grant_v_o !== 1'b1 || grant_tid_o !== 2'd3)
            $display("FAIL b2b_drain_restart got state=%h v=%b tid=%0d exp 40/1/3", state_o, grant_v_o, grant_tid_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_rr_stall();
        test_drain();
        test_err();
        test_saturation();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
